// File: rtl/wb_regfile_writer.sv
// rtl/wb_regfile_writer.sv - MEM/WB register, register-file write port and RAW scoreboard
// Optional scoreboard built only when WB_SCOREBOARD_EN is defined.
module wb_regfile_writer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_mem,
  input  logic             stall_wb,
  input  logic             flush,
  input  logic             mem_wreg,
  input  logic [4:0]       mem_wd,
  input  logic [31:0]      mem_wdata,
  input  logic             id_issue,
  input  logic             id_wreg,
  input  logic [4:0]       id_wd,
  input  logic [4:0]       id_raddr1,
  input  logic [4:0]       id_raddr2,
  output logic             wb_we,
  output logic [4:0]       wb_waddr,
  output logic [31:0]      wb_wdata,
  output logic             busy1,
  output logic             busy2,
  output logic [31:0]      busy_vec,
  output logic [CNT_W-1:0] wr_count,
  output logic             sb_err
);

  always_ff @(posedge clk) begin
    if (rst || flush || (stall_mem && !stall_wb)) begin
      wb_we    <= 1'b0;
      wb_waddr <= 5'd0;
      wb_wdata <= 32'd0;
    end else if (!stall_mem) begin
      // r0 is hardwired, so a write to it is dropped here rather than at the regfile
      wb_we    <= mem_wreg && (mem_wd != 5'd0);
      wb_waddr <= mem_wd;
      wb_wdata <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      wr_count <= '0;
    else if (wb_we)
      wr_count <= wr_count + CNT_W'(1);
  end

`ifdef WB_SCOREBOARD_EN
  logic [1:0] cnt     [32];
  logic [1:0] cnt_nxt [32];
  logic       err_q;
  logic       err_nxt;

  always_comb begin
    logic inc;
    logic dec;
    inc     = 1'b0;
    dec     = 1'b0;
    err_nxt = err_q;
    for (int r = 0; r < 32; r++) begin
      cnt_nxt[r] = cnt[r];
      if (r != 0) begin
        inc = id_issue && id_wreg && (id_wd == 5'(r));
        dec = wb_we && (wb_waddr == 5'(r));
        if (inc && !dec) begin
          if (cnt[r] == 2'd3) err_nxt = 1'b1;
          else                cnt_nxt[r] = cnt[r] + 2'd1;
        end else if (dec && !inc) begin
          if (cnt[r] == 2'd0) err_nxt = 1'b1;
          else                cnt_nxt[r] = cnt[r] - 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) cnt[r] <= 2'd0;
      err_q <= 1'b0;
    end else if (flush) begin
      for (int r = 0; r < 32; r++) cnt[r] <= 2'd0;
    end else begin
      for (int r = 0; r < 32; r++) cnt[r] <= cnt_nxt[r];
      err_q <= err_nxt;
    end
  end

  always_comb begin
    busy_vec = 32'd0;
    for (int r = 1; r < 32; r++) busy_vec[r] = (cnt[r] != 2'd0);
  end

  // A last pending write sitting on the write port is covered by the regfile bypass
  always_comb begin
    busy1 = (id_raddr1 != 5'd0) && (cnt[id_raddr1] != 2'd0) &&
            !((cnt[id_raddr1] == 2'd1) && wb_we && (wb_waddr == id_raddr1));
    busy2 = (id_raddr2 != 5'd0) && (cnt[id_raddr2] != 2'd0) &&
            !((cnt[id_raddr2] == 2'd1) && wb_we && (wb_waddr == id_raddr2));
  end

  assign sb_err = err_q;
`else
  logic unused_sb;
  assign unused_sb = ^{id_issue, id_wreg, id_wd, id_raddr1, id_raddr2};
  assign busy1     = 1'b0;
  assign busy2     = 1'b0;
  assign busy_vec  = 32'd0;
  assign sb_err    = 1'b0;
`endif

endmodule

// File: tb/tb_wb_regfile_writer.sv
// tb/tb_wb_regfile_writer.sv - scoreboard bench for wb_regfile_writer
// Scoreboard expectations depend on WB_SCOREBOARD_EN; disabled build expects tied-zero outputs.
module tb_wb_regfile_writer;
  logic        clk = 1'b0;
  logic        rst, stall_mem, stall_wb, flush;
  logic        mem_wreg, id_issue, id_wreg;
  logic [4:0]  mem_wd, id_wd, id_raddr1, id_raddr2;
  logic [31:0] mem_wdata;
  logic        wb_we, busy1, busy2, sb_err;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata, busy_vec;
  logic [3:0]  wr_count;

  wb_regfile_writer #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush),
    .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
    .id_issue(id_issue), .id_wreg(id_wreg), .id_wd(id_wd),
    .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .busy1(busy1), .busy2(busy2), .busy_vec(busy_vec),
    .wr_count(wr_count), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      0:       return {31'd0, wb_we};
      1:       return {27'd0, wb_waddr};
      2:       return wb_wdata;
      3:       return {31'd0, busy1};
      4:       return {31'd0, busy2};
      5:       return busy_vec;
      6:       return {28'd0, wr_count};
      default: return {31'd0, sb_err};
    endcase
  endfunction

  // Monitor: compares every expectation due in the current cycle, away from the edge
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        checks++;
        if (sample(q[i].sel) !== q[i].val) begin
          failures++;
          $display("FAIL %s: got %h expected %h (cycle %0d)", q[i].name, sample(q[i].sel), q[i].val, cyc);
        end
        q.delete(i);
      end
    end
  end

  task automatic ex(input int sel, input logic [31:0] v, input string n);
    exp_t e;
    e.cyc = cyc; e.sel = sel; e.val = v; e.name = n;
    q.push_back(e);
  endtask

  task automatic exsb(input int sel, input logic [31:0] v, input string n);
`ifdef WB_SCOREBOARD_EN
    ex(sel, v, n);
`else
    ex(sel, 32'd0, n);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mem(input logic w, input logic [4:0] d, input logic [31:0] v);
    mem_wreg = w; mem_wd = d; mem_wdata = v;
  endtask

  task automatic iss(input logic i, input logic [4:0] d);
    id_issue = i; id_wreg = i; id_wd = d;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    stall_mem = 0; stall_wb = 0; flush = 0; id_raddr1 = 0; id_raddr2 = 0;
    rst = 1; mem(1, 5'd7, 32'hdeadbeef); iss(1, 5'd7);
    step(); step();
    // reset state
    rst = 0; mem(1, 5'd3, 32'h0000000a); iss(1, 5'd3);
    ex(0, 0, "rst_we"); ex(1, 0, "rst_waddr"); ex(2, 0, "rst_wdata");
    ex(6, 0, "rst_wr_count"); ex(5, 0, "rst_busy_vec"); ex(7, 0, "rst_sb_err");
    step();
    mem(0, 0, 0); iss(0, 0); id_raddr1 = 5'd3;
    ex(0, 1, "w3_we"); ex(1, 3, "w3_waddr"); ex(2, 32'h0000000a, "w3_wdata");
    exsb(5, 32'h8, "w3_busy_vec"); ex(3, 0, "w3_busy1_bypass");
    step();
    ex(6, 1, "w3_wr_count"); ex(0, 0, "w3_we_after"); exsb(5, 0, "w3_busy_vec_clear");
    // address 0 write is dropped
    mem(1, 5'd0, 32'h55);
    step();
    mem(0, 0, 0);
    ex(0, 0, "a0_we");
    step();
    ex(6, 1, "a0_wr_count");
    // stall bubble
    mem(1, 5'd4, 32'h44); iss(1, 5'd4);
    step();
    stall_mem = 1; mem(1, 5'd6, 32'h66); iss(0, 0);
    ex(0, 1, "r4_we");
    step();
    ex(0, 0, "bubble_we"); ex(1, 0, "bubble_waddr"); ex(2, 0, "bubble_wdata"); ex(6, 2, "bubble_wr_count");
    stall_mem = 0; mem(0, 5'd12, 32'hbeef);
    step();
    stall_mem = 1; stall_wb = 1; mem(1, 5'd13, 32'h1);
    step(); step();
    ex(0, 0, "hold_we"); ex(1, 12, "hold_waddr"); ex(2, 32'hbeef, "hold_wdata");
    stall_mem = 0; stall_wb = 0; mem(0, 0, 0);
    // hazard on r5
    iss(1, 5'd5);
    step();
    mem(1, 5'd5, 32'h51);
    step();
    iss(0, 0); mem(1, 5'd5, 32'h52); id_raddr1 = 5'd5; id_raddr2 = 5'd5;
    exsb(5, 32'h20, "r5_busy_vec"); exsb(3, 1, "r5_busy1_cnt2"); exsb(4, 1, "r5_busy2_cnt2");
    step();
    mem(0, 0, 0);
    exsb(3, 0, "r5_busy1_cnt1_bypass"); exsb(4, 0, "r5_busy2_cnt1_bypass"); exsb(5, 32'h20, "r5_busy_vec_cnt1");
    step();
    ex(6, 4, "r5_wr_count"); exsb(5, 0, "r5_busy_vec_clear"); exsb(3, 0, "r5_busy1_clear"); exsb(7, 0, "r5_sb_err");
    // simultaneous inc/dec on r7
    iss(1, 5'd7); mem(1, 5'd7, 32'h70);
    step();
    mem(0, 0, 0);
    step();
    iss(0, 0); id_raddr1 = 5'd7;
    exsb(5, 32'h80, "r7_incdec_busy_vec"); exsb(3, 1, "r7_busy1_no_bypass"); ex(6, 5, "r7_wr_count");
    // overflow on r9
    iss(1, 5'd9);
    step(); step(); step();
    exsb(7, 0, "r9_no_err_at_3");
    step();
    iss(0, 0); flush = 1; mem(1, 5'd9, 32'h99);
    exsb(7, 1, "r9_overflow_err"); exsb(5, 32'h280, "r9_busy_vec");
    step();
    flush = 0; mem(0, 0, 0);
    ex(0, 0, "flush_we"); exsb(5, 0, "flush_busy_vec"); exsb(3, 0, "flush_busy1");
    exsb(7, 1, "flush_err_sticky"); ex(6, 5, "flush_wr_count");
    // wr_count wrap with CNT_W=4
    mem(1, 5'd10, 32'ha0); iss(1, 5'd10);
    for (int k = 0; k < 11; k++) step();
    ex(6, 15, "wrap_wr_count_15");
    mem(0, 0, 0); iss(0, 0);
    step();
    ex(6, 0, "wrap_wr_count_0"); exsb(5, 0, "wrap_busy_vec");
    step(); step();
    if (q.size() != 0) begin
      checks++; failures++;
      $display("FAIL pending: got %0d unchecked expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
